// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Holds the FSM states, default widths, requester IDs and the saturating streak increment.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STREAK_W   = 4;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                  input logic [STREAK_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Winner selection between fetch and data (data first, bounded by the streak limit).
// Purely combinational; also produces the streak counter's next value.
module arb_prio_pick
  import cpu_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_if_req,
  input  logic                i_d_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_grant_vld,
  output logic                o_grant_who,
  output logic [STREAK_W-1:0] o_streak_nxt
);

  localparam logic [STREAK_W-1:0] LP_MAX = STREAK_W'(MAX_D_STREAK);

  logic w_d_win;

  always_comb begin
    w_d_win      = i_d_req & (~i_if_req | (i_streak < LP_MAX));
    o_grant_vld  = i_if_req | i_d_req;
    o_grant_who  = w_d_win ? REQ_D : REQ_IF;
    // Only data wins taken while fetch is waiting count towards the streak.
    o_streak_nxt = (w_d_win & i_if_req) ? sat_inc(i_streak, LP_MAX) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; min 3 cycles req->ready, mem_req held until mem_ack.
// Optional perf counters (perf_if_wait/perf_d_wait/perf_xfers) enabled by ARB_PERF_CNT_EN.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait,
  output logic [31:0]       perf_xfers,
`endif
  output logic              grant_d
);

  arb_state_t          r_state, w_state_nxt;
  logic [STREAK_W-1:0] r_streak, w_streak_nxt;
  logic                w_grant_vld, w_grant_who;
  logic                r_mem_req, r_mem_we, r_grant_d;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, r_if_rdata, r_d_rdata;

  arb_prio_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
    .i_if_req     (if_req),
    .i_d_req      (d_req),
    .i_streak     (r_streak),
    .o_grant_vld  (w_grant_vld),
    .o_grant_who  (w_grant_who),
    .o_streak_nxt (w_streak_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if_ready    = 1'b0;
    d_ready     = 1'b0;
    case (r_state)
      IDLE:           if (w_grant_vld) w_state_nxt = (w_grant_who == REQ_D) ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (mem_ack) w_state_nxt = RESP;
      RESP: begin
        w_state_nxt = IDLE;
        if_ready    = (r_grant_d == REQ_IF);
        d_ready     = (r_grant_d == REQ_D);
      end
      default:        w_state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at grant; later requester changes are invisible to memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_grant_d   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_streak <= w_streak_nxt;
          if (w_grant_vld) begin
            r_mem_req <= 1'b1;
            r_grant_d <= w_grant_who;
            if (w_grant_who == REQ_D) begin
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        BUSY_I: if (mem_ack) begin
          r_mem_req  <= 1'b0;
          r_if_rdata <= mem_rdata;
        end
        BUSY_D: if (mem_ack) begin
          r_mem_req <= 1'b0;
          if (!r_mem_we) r_d_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign grant_d   = r_grant_d;

`ifdef ARB_PERF_CNT_EN
  logic w_ack_ok;
  assign w_ack_ok = mem_ack & ((r_state == BUSY_I) | (r_state == BUSY_D));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
      perf_xfers   <= '0;
    end else begin
      if (if_req & ~if_ready) perf_if_wait <= perf_if_wait + 32'd1;
      if (d_req & ~d_ready)   perf_d_wait  <= perf_d_wait + 32'd1;
      if (w_ack_ok)           perf_xfers   <= perf_xfers + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, grant_d;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_d_wait, perf_xfers;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef ARB_PERF_CNT_EN
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait), .perf_xfers(perf_xfers),
`endif
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  txn_t        d_q[$];
  logic [31:0] if_q[$];
  bit          ev_q[$];
  logic [31:0] rd_q[$];
  txn_t        mlog[$];
  logic [31:0] mem[logic [31:0]];
  int          ack_delay = 0;
  bit          rnd_delay = 1'b0;
  bit          spur = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] defval(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: acks after ack_delay waiting cycles (or random), applies stores, logs every transfer.
  initial begin : mem_model
    int   cnt;
    bit   active;
    txn_t t;
    cnt = 0; active = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        if (!active) begin
          active = 1'b1;
          cnt = rnd_delay ? int'($urandom_range(0, 4)) : ack_delay;
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          active  = 1'b0;
          t = mk(mem_we, mem_addr, mem_wdata);
          mlog.push_back(t);
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : defval(mem_addr);
        end else begin
          cnt--;
        end
      end else begin
        active = 1'b0;
        if (spur) begin
          mem_ack = 1'b1;
          mem_rdata = 32'hBADB_AD00;
        end
      end
    end
  end

  task automatic present_d();
    d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
  endtask

  task automatic start();
    if (if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0]; end
    if (d_q.size() > 0) present_d();
  endtask

  // One clock; requesters retire on ready and present their next queued request at once.
  task automatic tick();
    txn_t t;
    logic [31:0] a;
    @(posedge clk); #1;
    chk("no_overlap", 32'(if_ready & d_ready), 32'd0);
    if (if_ready) begin
      ev_q.push_back(1'b0); rd_q.push_back(if_rdata);
      if (if_q.size() > 0) a = if_q.pop_front();
      if (if_q.size() > 0) if_addr = if_q[0]; else if_req = 1'b0;
    end
    if (d_ready) begin
      ev_q.push_back(1'b1); rd_q.push_back(d_rdata);
      if (d_q.size() > 0) t = d_q.pop_front();
      if (d_q.size() > 0) present_d(); else d_req = 1'b0;
    end
  endtask

  task automatic wait_evts(input int k, input int budget, output int n);
    n = 0;
    while (ev_q.size() < k && n < budget) begin tick(); n++; end
    chk("evt_timeout", 32'(ev_q.size() >= k), 32'd1);
  endtask

  task automatic clr();
    ev_q.delete(); rd_q.delete(); mlog.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          n, ni, nd, a, b, s;
    logic [31:0] exp_d_rd, x;
    bit          exp4[10];
    bit          eo[$];
    logic [31:0] ed[$];
    txn_t        et[$], eds[$], t;
    logic [31:0] eis[$];
    logic [31:0] mm[logic [31:0]];

    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    chk("rst_grant_d", 32'(grant_d), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();
    mem[32'h100] = 32'h0050_0093; mem[32'h104] = 32'h3333_4444; mem[32'h2000] = 32'h1111_2222;

    // Single fetch
    clr();
    if_q.push_back(32'h100); start();
    tick();
    chk("t1_mem_req", 32'(mem_req), 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", 32'(mem_we), 0);
    wait_evts(1, 20, n);
    chk("t1_ready_edges", 32'(n + 1), 2);
    chk("t1_who", 32'(ev_q[0]), 0);
    chk("t1_rdata", rd_q[0], 32'h0050_0093);
    tick();
    chk("t1_pulse_once", 32'(if_ready), 0);

    // Simultaneous requests: data first
    clr();
    if_q.push_back(32'h104); d_q.push_back(mk(1'b0, 32'h2000, 0)); start();
    tick();
    chk("t2_grant_d", 32'(grant_d), 1);
    chk("t2_mem_addr", mem_addr, 32'h2000);
    wait_evts(2, 30, n);
    chk("t2_first", 32'(ev_q[0]), 1);
    chk("t2_second", 32'(ev_q[1]), 0);
    chk("t2_d_rdata", rd_q[0], 32'h1111_2222);
    chk("t2_if_rdata", rd_q[1], 32'h3333_4444);
    exp_d_rd = 32'h1111_2222;
    tick();

    // Store
    clr();
    d_q.push_back(mk(1'b1, 32'h2004, 32'hDEAD_BEEF)); start();
    tick();
    chk("t3_mem_we", 32'(mem_we), 1);
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_addr", mem_addr, 32'h2004);
    wait_evts(1, 20, n);
    chk("t3_d_rdata_kept", rd_q[0], exp_d_rd);
    chk("t3_mem_written", mem[32'h2004], 32'hDEAD_BEEF);
    tick();

    // Starvation guard: 4 data, fetch, then a fresh streak of 4
    clr();
    for (int k = 0; k < 8; k++) d_q.push_back(mk(1'b0, 32'h3000 + 32'(4 * k), 0));
    if_q.push_back(32'h108); if_q.push_back(32'h10C);
    start();
    exp4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    wait_evts(10, 150, n);
    for (int k = 0; k < 10; k++)
      if (k < ev_q.size()) chk($sformatf("t4_order%0d", k), 32'(ev_q[k]), 32'(exp4[k]));
    exp_d_rd = defval(32'h301C);
    tick();

    // Slow memory, data inputs altered while waiting
    clr();
    ack_delay = 10;
    d_q.push_back(mk(1'b0, 32'h2000, 0)); start();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_mem_req_hold", 32'(mem_req), 1);
      chk("t5_mem_addr_hold", mem_addr, 32'h2000);
      if (i == 2) begin d_addr = 32'h5555_0000; d_we = 1'b1; end
    end
    wait_evts(1, 30, n);
    chk("t5_log_addr", mlog[0].addr, 32'h2000);
    chk("t5_log_we", 32'(mlog[0].we), 0);
    chk("t5_rdata", rd_q[0], 32'h1111_2222);
    exp_d_rd = 32'h1111_2222;
    ack_delay = 0;
    tick();

    // Stray acks while idle are ignored
    clr();
    spur = 1'b1;
    repeat (4) tick();
    spur = 1'b0;
    tick();
    chk("sp_no_ready", 32'(ev_q.size()), 0);
    chk("sp_if_rdata", if_rdata, defval(32'h10C));
    chk("sp_d_rdata", d_rdata, exp_d_rd);
    chk("sp_mem_req", 32'(mem_req), 0);

    // Reset in the middle of a data transfer
    clr();
    ack_delay = 20;
    d_q.push_back(mk(1'b0, 32'h2000, 0)); start();
    tick(); tick();
    chk("t6_busy_req", 32'(mem_req), 1);
    chk("t6_busy_grant", 32'(grant_d), 1);
    #2; rst = 1'b1; #1;
    chk("t6_rst_mem_req", 32'(mem_req), 0);
    chk("t6_rst_grant_d", 32'(grant_d), 0);
    chk("t6_rst_d_ready", 32'(d_ready), 0);
    chk("t6_rst_if_ready", 32'(if_ready), 0);
    d_req = 1'b0; if_req = 1'b0; d_q.delete(); if_q.delete();
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_if", perf_if_wait, 0);
    chk("t6_perf_d", perf_d_wait, 0);
    chk("t6_perf_x", perf_xfers, 0);
`endif
    tick(); tick();
    rst = 1'b0; ack_delay = 0;
    tick();
    clr();
    if_q.push_back(32'h100); start();
    wait_evts(1, 20, n);
    chk("t6_fetch_rdata", rd_q[0], 32'h0050_0093);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_if_after", perf_if_wait, 2);
    chk("t6_perf_x_after", perf_xfers, 1);
`endif
    exp_d_rd = 32'h0;
    tick();

    // Random traffic against a transaction-level model of the policy
    rnd_delay = 1'b1;
    for (int r = 0; r < 6; r++) begin
      clr(); eo.delete(); ed.delete(); et.delete(); eds.delete(); eis.delete();
      ni = int'($urandom_range(0, 4));
      nd = int'($urandom_range(1, 8));
      for (int k = 0; k < ni; k++) eis.push_back(32'h8000 + 32'(4 * $urandom_range(0, 3)));
      for (int k = 0; k < nd; k++)
        eds.push_back(mk(1'($urandom_range(0, 1)), 32'h4000 + 32'(4 * $urandom_range(0, 7)), $urandom));
      a = 0; b = 0; s = 0;
      while (a < ni || b < nd) begin
        if (b < nd && (a >= ni || s < MAXS)) begin
          t = eds[b]; b++;
          eo.push_back(1'b1); et.push_back(t);
          if (!t.we) exp_d_rd = mm.exists(t.addr) ? mm[t.addr] : defval(t.addr);
          else mm[t.addr] = t.wdata;
          ed.push_back(exp_d_rd);
          s = (a < ni) ? s + 1 : 0;
        end else begin
          x = eis[a]; a++;
          eo.push_back(1'b0); et.push_back(mk(1'b0, x, 0));
          ed.push_back(mm.exists(x) ? mm[x] : defval(x));
          s = 0;
        end
      end
      for (int k = 0; k < ni; k++) if_q.push_back(eis[k]);
      for (int k = 0; k < nd; k++) d_q.push_back(eds[k]);
      start();
      wait_evts(ni + nd, (ni + nd) * 12 + 20, n);
      chk("rnd_count", 32'(ev_q.size()), 32'(ni + nd));
      for (int k = 0; k < eo.size(); k++) begin
        if (k < ev_q.size() && k < mlog.size()) begin
          chk($sformatf("rnd%0d_who%0d", r, k), 32'(ev_q[k]), 32'(eo[k]));
          chk($sformatf("rnd%0d_rdata%0d", r, k), rd_q[k], ed[k]);
          chk($sformatf("rnd%0d_addr%0d", r, k), mlog[k].addr, et[k].addr);
          chk($sformatf("rnd%0d_we%0d", r, k), 32'(mlog[k].we), 32'(et[k].we));
          if (et[k].we) chk($sformatf("rnd%0d_wdata%0d", r, k), mlog[k].wdata, et[k].wdata);
        end
      end
      tick(); tick();
    end
    rnd_delay = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
